// File: rtl/ram_channel_arbiter.sv
// Round-robin arbiter that funnels one pending request slot per client onto a
// single downstream RAM channel, with a bounded wait for the memory acknowledge.
module ram_channel_arbiter #(
    parameter int CLIENTS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2*CLIENTS-1:0]  cl_size,
    input  logic [CLIENTS-1:0]    cl_write,
    input  logic [32*CLIENTS-1:0] cl_addr,
    input  logic [32*CLIENTS-1:0] cl_wdata,
    output logic [32*CLIENTS-1:0] cl_rdata,
    output logic [CLIENTS-1:0]    cl_ready,
    output logic [CLIENTS-1:0]    cl_done,
    output logic [CLIENTS-1:0]    cl_error,
    output logic                  mem_req,
    output logic [1:0]            mem_size,
    output logic                  mem_write,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam int PW = $clog2(CLIENTS);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RETIRE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [CLIENTS-1:0]    pend_q, pend_d;
    logic [2*CLIENTS-1:0]  slot_size_q, slot_size_d;
    logic [CLIENTS-1:0]    slot_write_q, slot_write_d;
    logic [32*CLIENTS-1:0] slot_addr_q, slot_addr_d;
    logic [32*CLIENTS-1:0] slot_wdata_q, slot_wdata_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic [PW-1:0]         gnt_q, gnt_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic [1:0]            mem_size_q, mem_size_d;
    logic                  mem_write_q, mem_write_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [32*CLIENTS-1:0] cl_rdata_q, cl_rdata_d;
    logic [CLIENTS-1:0]    cl_done_q, cl_done_d;
    logic [CLIENTS-1:0]    cl_error_q, cl_error_d;

    logic                  found_s;
    logic [PW-1:0]         pick_s;
    logic [PW:0]           idx_s;
    logic                  tmo_s;
    logic                  fin_s;

    // Round-robin search: walk downwards so the index nearest rr_q wins last.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = '0;
        for (int k = CLIENTS - 1; k >= 0; k--) begin
            idx_s   = {1'b0, rr_q} + (PW+1)'(k);
            idx_s   = (idx_s >= (PW+1)'(CLIENTS)) ? idx_s - (PW+1)'(CLIENTS) : idx_s;
            found_s = found_s | pend_q[idx_s[PW-1:0]];
            pick_s  = pend_q[idx_s[PW-1:0]] ? idx_s[PW-1:0] : pick_s;
        end
    end

    // Slot capture, grant/complete FSM and response generation.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        slot_size_d  = slot_size_q;
        slot_write_d = slot_write_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_size_d   = mem_size_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cl_rdata_d   = cl_rdata_q;
        cl_done_d    = '0;
        cl_error_d   = '0;
        tmo_s        = (cnt_q == 8'(TIMEOUT - 1)) && !mem_ack;
        fin_s        = mem_ack || (cnt_q == 8'(TIMEOUT - 1));

        for (int i = 0; i < CLIENTS; i++) begin
            if ((cl_size[2*i +: 2] != 2'd0) && !pend_q[i]) begin
                pend_d[i]               = 1'b1;
                slot_size_d[2*i +: 2]   = cl_size[2*i +: 2];
                slot_write_d[i]         = cl_write[i];
                slot_addr_d[32*i +: 32] = cl_addr[32*i +: 32];
                slot_wdata_d[32*i +: 32] = cl_wdata[32*i +: 32];
            end else begin
                pend_d[i] = pend_d[i];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_d       = pick_s;
                    mem_req_d   = 1'b1;
                    mem_size_d  = slot_size_q[2*int'(pick_s) +: 2];
                    mem_write_d = slot_write_q[pick_s];
                    mem_addr_d  = slot_addr_q[32*int'(pick_s) +: 32];
                    mem_wdata_d = slot_wdata_q[32*int'(pick_s) +: 32];
                    cnt_d       = 8'd0;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // An ack arriving on the timeout edge still counts as success.
                if (fin_s) begin
                    mem_req_d         = 1'b0;
                    mem_size_d        = 2'd0;
                    cl_done_d[gnt_q]  = 1'b1;
                    cl_error_d[gnt_q] = tmo_s;
                    pend_d[gnt_q]     = 1'b0;
                    rr_d              = (gnt_q == PW'(CLIENTS - 1)) ? '0 : gnt_q + PW'(1);
                    state_d           = ST_RETIRE;
                    if (mem_ack && !mem_write_q) begin
                        cl_rdata_d[32*int'(gnt_q) +: 32] = mem_rdata;
                    end else begin
                        cl_rdata_d = cl_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RETIRE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            slot_size_q  <= '0;
            slot_write_q <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            rr_q         <= '0;
            gnt_q        <= '0;
            cnt_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_size_q   <= 2'd0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            cl_rdata_q   <= '0;
            cl_done_q    <= '0;
            cl_error_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            slot_size_q  <= slot_size_d;
            slot_write_q <= slot_write_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_size_q   <= mem_size_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cl_rdata_q   <= cl_rdata_d;
            cl_done_q    <= cl_done_d;
            cl_error_q   <= cl_error_d;
        end
    end

    assign cl_ready  = ~pend_q;
    assign cl_rdata  = cl_rdata_q;
    assign cl_done   = cl_done_q;
    assign cl_error  = cl_error_q;
    assign mem_req   = mem_req_q;
    assign mem_size  = mem_size_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_channel_arbiter.sv
// Directed bench for ram_channel_arbiter (4 clients, short ack timeout of 4 cycles).
module tb_ram_channel_arbiter;

    localparam int CLIENTS = 4;
    localparam int TIMEOUT = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [2*CLIENTS-1:0]  cl_size;
    logic [CLIENTS-1:0]    cl_write;
    logic [32*CLIENTS-1:0] cl_addr;
    logic [32*CLIENTS-1:0] cl_wdata;
    logic [32*CLIENTS-1:0] cl_rdata;
    logic [CLIENTS-1:0]    cl_ready;
    logic [CLIENTS-1:0]    cl_done;
    logic [CLIENTS-1:0]    cl_error;
    logic                  mem_req;
    logic [1:0]            mem_size;
    logic                  mem_write;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_channel_arbiter #(.CLIENTS(CLIENTS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cl_size(cl_size), .cl_write(cl_write), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
        .cl_rdata(cl_rdata), .cl_ready(cl_ready), .cl_done(cl_done), .cl_error(cl_error),
        .mem_req(mem_req), .mem_size(mem_size), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic [1:0] sz, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
        cl_size[2*i +: 2]  = sz;
        cl_write[i]        = wr;
        cl_addr[32*i +: 32]  = a;
        cl_wdata[32*i +: 32] = wd;
    endtask

    task automatic drop(input int i);
        cl_size[2*i +: 2] = 2'd0;
    endtask

    // Advances until mem_req is seen at a negedge; returns edges waited (99 on expiry).
    task automatic wait_grant(output int n);
        n = 0;
        while (!mem_req && n < 10) begin
            tick;
            @(negedge clk);
            n++;
        end
        if (!mem_req) n = 99;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req(0, 2'd3, 1'b1, 32'hFFFF_FFFC, 32'h1);
        req(2, 2'd1, 1'b0, 32'h0000_0010, 32'h2);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick; tick;
        @(negedge clk);
        n_cmp++; if (cl_ready !== 4'hF) begin n_bad++; $display("FAIL rst_ready: got %h want f", cl_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %h want 0", mem_req); end
        n_cmp++; if ({mem_size, mem_write, mem_addr, mem_wdata} !== 67'd0) begin n_bad++; $display("FAIL rst_mem_fields: got %h/%h/%h/%h want 0", mem_size, mem_write, mem_addr, mem_wdata); end
        n_cmp++; if ({cl_done, cl_error} !== 8'h00) begin n_bad++; $display("FAIL rst_done_err: got %h/%h want 0/0", cl_done, cl_error); end
        n_cmp++; if (cl_rdata !== 128'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", cl_rdata); end
        reset_n = 1'b1; cl_size = '0; mem_ack = 1'b0; mem_rdata = 32'd0;
        tick;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_release_idle: got %h want 0", mem_req); end
    endtask

    task automatic test_round_robin;
        int   ord[2] = '{0, 3};
        logic [31:0] ea[2] = '{32'h0000_2000, 32'h0000_2003};
        logic [31:0] ew[2] = '{32'h1111_1111, 32'h0000_00EE};
        logic [1:0]  es[2] = '{2'd3, 2'd1};
        for (int i = 0; i < 4; i++) req(i, 2'd3, 1'b0, 32'h1000 + 32'(i) * 32'h10, 32'd0);
        tick;
        cl_size = '0;
        @(negedge clk);
        n_cmp++; if (cl_ready !== 4'h0) begin n_bad++; $display("FAIL rr_latch_ready: got %h want 0", cl_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rr_no_grant_on_latch: got %h want 0", mem_req); end
        // After the first grant, mem_req stays low for the done cycle and the IDLE cycle.
        for (int g = 0; g < 4; g++) begin
            int n;
            wait_grant(n);
            n_cmp++; if (n !== ((g == 0) ? 1 : 2)) begin n_bad++; $display("FAIL rr_gap_%0d: got %0d want %0d", g, n, (g == 0) ? 1 : 2); end
            n_cmp++; if (mem_addr !== 32'h1000 + 32'(g) * 32'h10) begin n_bad++; $display("FAIL rr_order_%0d: got %h want %h", g, mem_addr, 32'h1000 + 32'(g) * 32'h10); end
            mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(g);
            tick;
            mem_ack = 1'b0;
            @(negedge clk);
            n_cmp++; if (cl_done !== 4'(1 << g)) begin n_bad++; $display("FAIL rr_done_%0d: got %h want %h", g, cl_done, 4'(1 << g)); end
            n_cmp++; if (cl_rdata[32*g +: 32] !== 32'hA000_0000 + 32'(g)) begin n_bad++; $display("FAIL rr_rdata_%0d: got %h want %h", g, cl_rdata[32*g +: 32], 32'hA000_0000 + 32'(g)); end
        end
        req(3, 2'd1, 1'b1, 32'h2003, 32'h0000_00EE);
        req(0, 2'd3, 1'b1, 32'h2000, 32'h1111_1111);
        tick;
        cl_size = '0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int n;
            wait_grant(n);
            n_cmp++; if (n == 99) begin n_bad++; $display("FAIL rr2_grant_%0d: got timeout want grant", k); end
            n_cmp++; if ({mem_addr, mem_wdata, mem_size, mem_write} !== {ea[k], ew[k], es[k], 1'b1}) begin n_bad++; $display("FAIL rr2_fields_%0d: got %h/%h/%h/%h want %h/%h/%h/1", k, mem_addr, mem_wdata, mem_size, mem_write, ea[k], ew[k], es[k]); end
            mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
            tick;
            mem_ack = 1'b0;
            @(negedge clk);
            n_cmp++; if (cl_done !== 4'(1 << ord[k])) begin n_bad++; $display("FAIL rr2_done_%0d: got %h want %h", k, cl_done, 4'(1 << ord[k])); end
            n_cmp++; if (cl_rdata[32*ord[k] +: 32] !== 32'hA000_0000 + 32'(ord[k])) begin n_bad++; $display("FAIL rr2_write_keeps_rdata_%0d: got %h want %h", k, cl_rdata[32*ord[k] +: 32], 32'hA000_0000 + 32'(ord[k])); end
            n_cmp++; if (mem_size !== 2'd0) begin n_bad++; $display("FAIL rr2_size_idle_%0d: got %h want 0", k, mem_size); end
        end
    endtask

    task automatic test_single_read;
        tick; tick;
        req(1, 2'd3, 1'b0, 32'h0000_0100, 32'd0);
        tick;
        drop(1);
        @(negedge clk);
        n_cmp++; if (cl_ready !== 4'b1101) begin n_bad++; $display("FAIL rd_ready_low: got %h want d", cl_ready); end
        tick;
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_size, mem_write, mem_addr} !== {1'b1, 2'd3, 1'b0, 32'h100}) begin n_bad++; $display("FAIL rd_issue: got %h/%h/%h/%h want 1/3/0/100", mem_req, mem_size, mem_write, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        n_cmp++; if ({cl_done, cl_error} !== 8'b0010_0000) begin n_bad++; $display("FAIL rd_done: got %h/%h want 2/0", cl_done, cl_error); end
        n_cmp++; if (cl_rdata[63:32] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", cl_rdata[63:32]); end
        n_cmp++; if ({cl_ready, mem_req} !== 5'b1111_0) begin n_bad++; $display("FAIL rd_ready_back: got %h/%h want f/0", cl_ready, mem_req); end
        tick;
        @(negedge clk);
        n_cmp++; if (cl_done !== 4'h0) begin n_bad++; $display("FAIL rd_done_pulse: got %h want 0", cl_done); end
    endtask

    task automatic test_no_starvation;
        int n;
        tick;
        req(0, 2'd3, 1'b0, 32'h0000_3000, 32'd0);
        tick;
        req(2, 2'd3, 1'b0, 32'h0000_3200, 32'd0);
        tick;
        drop(2);
        @(negedge clk);
        // Client 2 latched on the grant edge must not win even though rr points at it.
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h3000}) begin n_bad++; $display("FAIL ns_same_edge: got %h/%h want 1/3000", mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (cl_done !== 4'b0001) begin n_bad++; $display("FAIL ns_done0: got %h want 1", cl_done); end
        tick;
        drop(0);
        @(negedge clk);
        n_cmp++; if (cl_ready !== 4'b1010) begin n_bad++; $display("FAIL ns_relatch: got %h want a", cl_ready); end
        wait_grant(n);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h3200}) begin n_bad++; $display("FAIL ns_client2_first: got %h/%h want 1/3200", mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (cl_done !== 4'b0100) begin n_bad++; $display("FAIL ns_done2: got %h want 4", cl_done); end
        wait_grant(n);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h3000}) begin n_bad++; $display("FAIL ns_client0_next: got %h/%h want 1/3000", mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (cl_done !== 4'b0001) begin n_bad++; $display("FAIL ns_done0b: got %h want 1", cl_done); end
    endtask

    task automatic test_timeout;
        int n;
        int hi;
        tick;
        req(3, 2'd3, 1'b0, 32'h0000_4000, 32'd0);
        tick;
        drop(3);
        @(negedge clk);
        wait_grant(n);
        hi = 0;
        while (mem_req && hi < 20) begin
            hi++;
            tick;
            @(negedge clk);
        end
        n_cmp++; if (hi !== TIMEOUT) begin n_bad++; $display("FAIL to_req_cycles: got %0d want %0d", hi, TIMEOUT); end
        n_cmp++; if ({cl_done, cl_error} !== 8'b1000_1000) begin n_bad++; $display("FAIL to_done_err: got %h/%h want 8/8", cl_done, cl_error); end
        n_cmp++; if (cl_rdata[127:96] !== 32'hA000_0003) begin n_bad++; $display("FAIL to_rdata_kept: got %h want a0000003", cl_rdata[127:96]); end
        tick;
        @(negedge clk);
        n_cmp++; if ({cl_done, cl_error} !== 8'h00) begin n_bad++; $display("FAIL to_pulse_end: got %h/%h want 0/0", cl_done, cl_error); end
        req(2, 2'd3, 1'b0, 32'h0000_4200, 32'd0);
        tick;
        drop(2);
        @(negedge clk);
        wait_grant(n);
        tick; tick; tick;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL to_cycle4_req: got %h want 1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if ({cl_done, cl_error} !== 8'b0100_0000) begin n_bad++; $display("FAIL to_ack_wins: got %h/%h want 4/0", cl_done, cl_error); end
        n_cmp++; if (cl_rdata[95:64] !== 32'h55AA_55AA) begin n_bad++; $display("FAIL to_ack_rdata: got %h want 55aa55aa", cl_rdata[95:64]); end
    endtask

    task automatic test_reset_mid_issue;
        int n;
        tick;
        req(1, 2'd3, 1'b1, 32'h0000_5000, 32'h1234_5678);
        tick;
        drop(1);
        @(negedge clk);
        wait_grant(n);
        n_cmp++; if ({mem_req, mem_write} !== 2'b11) begin n_bad++; $display("FAIL rm_write_issued: got %h/%h want 1/1", mem_req, mem_write); end
        reset_n = 1'b0;
        req(0, 2'd3, 1'b0, 32'h0000_6000, 32'd0);
        tick;
        reset_n = 1'b1;
        drop(0);
        req(1, 2'd3, 1'b0, 32'h0000_5100, 32'd0);
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_size, cl_ready, cl_done} !== {1'b0, 2'd0, 4'hF, 4'h0}) begin n_bad++; $display("FAIL rm_abort: got %h/%h/%h/%h want 0/0/f/0", mem_req, mem_size, cl_ready, cl_done); end
        n_cmp++; if (cl_rdata !== 128'd0) begin n_bad++; $display("FAIL rm_rdata_cleared: got %h want 0", cl_rdata); end
        tick;
        drop(1);
        @(negedge clk);
        n_cmp++; if ({cl_ready, cl_done} !== {4'b1101, 4'h0}) begin n_bad++; $display("FAIL rm_first_cycle_latch: got %h/%h want d/0", cl_ready, cl_done); end
        wait_grant(n);
        n_cmp++; if ({mem_req, mem_write, mem_addr} !== {1'b1, 1'b0, 32'h5100}) begin n_bad++; $display("FAIL rm_read_issue: got %h/%h/%h want 1/0/5100", mem_req, mem_write, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if ({cl_done, cl_error} !== 8'b0010_0000) begin n_bad++; $display("FAIL rm_read_done: got %h/%h want 2/0", cl_done, cl_error); end
        n_cmp++; if (cl_rdata[63:32] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rm_read_data: got %h want cafef00d", cl_rdata[63:32]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        cl_size   = '0;
        cl_write  = '0;
        cl_addr   = '0;
        cl_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        test_reset;
        test_round_robin;
        test_single_read;
        test_no_starvation;
        test_timeout;
        test_reset_mid_issue;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
